timer_mc_ahbl: RTL and testbench

Multi-channel AHB-Lite alarm timer. It is the parametrised successor to the two-alarm system timer and sits on the same AHB-Lite peripheral bus. A prescaled free-running tick counter drives NUM_CH independent alarm channels. Each channel can be one-shot or drift-free periodic, with per-channel interrupt status and masking. The tick count is exported as the system time base.

---
 rtl/timer_mc_pkg.sv | 33 +++
 rtl/timer_mc_channel.sv | 47 ++++
 rtl/timer_mc_ahbl.sv | 173 +++++++++++++++++
 tb/tb_timer_mc_ahbl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_mc_pkg.sv
// Shared constants, bus FSM state and captured-request payload for the
// multi-channel AHB-Lite alarm timer.
package timer_mc_pkg;

  localparam logic [7:0] OFF_STATUS   = 8'h00;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h04;
  localparam logic [7:0] OFF_TICKS    = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;
  localparam logic [7:0] OFF_GCTRL    = 8'h10;

  localparam logic [7:0] CH_BASE   = 8'h40;
  localparam logic [7:0] CH_STRIDE = 8'h10;
  localparam logic [3:0] CH_CTRL   = 4'h0;
  localparam logic [3:0] CH_PERIOD = 4'h4;
  localparam logic [3:0] CH_END    = 4'h8;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned GCTRL_RUN     = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_WAIT} bus_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic       write;
  } bus_req_t;

  // Channel number of a byte offset inside the per-channel window.
  function automatic logic [3:0] ch_index(input logic [7:0] addr);
    return 4'((addr - CH_BASE) / CH_STRIDE);
  endfunction

endpackage

// File: rtl/timer_mc_channel.sv
// One alarm channel: enable/mode bits, period, absolute END compare and
// drift-free reload.
module timer_mc_channel
  import timer_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [CNT_W-1:0] ticks,
  input  logic             ctrl_we,
  input  logic             period_we,
  input  logic [31:0]      wdata,
  output logic             en,
  output logic             periodic,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] alarm_end,
  output logic             fire_c
);

  // An arming write in the same cycle suppresses the fire.
  assign fire_c = tick & en & ((ticks + CNT_W'(1)) == alarm_end) & ~period_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      periodic  <= 1'b0;
      period    <= '0;
      alarm_end <= '0;
    end else if (period_we) begin
      period    <= wdata[CNT_W-1:0];
      alarm_end <= ticks + wdata[CNT_W-1:0];
      en        <= 1'b1;
    end else begin
      if (fire_c) begin
        if (periodic) alarm_end <= alarm_end + period;
        else          en        <= 1'b0;
      end
      if (ctrl_we) begin
        en       <= wdata[CTRL_EN];
        periodic <= wdata[CTRL_PERIODIC];
      end
    end
  end

endmodule

// File: rtl/timer_mc_ahbl.sv
// AHB-Lite multi-channel alarm timer: bus FSM, prescaler, tick counter,
// interrupt status/mask and read mux around NUM_CH alarm channels.
module timer_mc_ahbl
  import timer_mc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned PRESCALE   = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      ahbl_haddr_i,
  input  logic [1:0]       ahbl_htrans_i,
  input  logic             ahbl_hwrite_i,
  input  logic             ahbl_hsel_i,
  input  logic             ahbl_hready_i,
  input  logic [2:0]       ahbl_hsize_i,
  input  logic [2:0]       ahbl_hburst_i,
  input  logic [31:0]      ahbl_hwdata_i,
  output logic [31:0]      ahbl_hrdata_o,
  output logic             ahbl_hreadyout_o,
  output logic             ahbl_hresp_o,
  output logic             int_o,
  output logic [CNT_W-1:0] systime_o
);

  bus_state_t            state, state_next;
  bus_req_t              req;
  logic                  accept_c, hazard_c, wr_en, rd_load, hreadyout_next;
  logic [7:0]            addr_word, rd_addr;
  logic [31:0]           rd_data_c, hrdata_q;
  logic                  hreadyout_q, int_q, run, tick_c, ch_wr_c;
  logic [PRESCALE_W-1:0] prescale_q, tick_cnt;
  logic [CNT_W-1:0]      ticks;
  logic [NUM_CH-1:0]     status, irq_en, fire, en, periodic, ctrl_we, period_we;
  logic [CNT_W-1:0]      period    [NUM_CH];
  logic [CNT_W-1:0]      alarm_end [NUM_CH];
  logic                  we_status, we_irq_en, we_prescale, we_gctrl;
  logic                  unused_c;

  assign unused_c  = ^{ahbl_hsize_i, ahbl_hburst_i, ahbl_haddr_i[31:8], ahbl_haddr_i[1:0]};
  assign addr_word = {ahbl_haddr_i[7:2], 2'b00};
  assign accept_c  = ahbl_hsel_i & ahbl_htrans_i[1] & ahbl_hready_i;
  // Read address phase overlapping a write data phase must see the write.
  assign hazard_c  = (state == ST_DATA) & req.write & accept_c & ~ahbl_hwrite_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_c) state_next = ST_DATA;
      ST_DATA: begin
        if (!accept_c)     state_next = ST_IDLE;
        else if (hazard_c) state_next = ST_WAIT;
        else               state_next = ST_DATA;
      end
      ST_WAIT: state_next = ST_DATA;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en          = 1'b0;
    rd_load        = 1'b0;
    hreadyout_next = 1'b1;
    wr_en          = (state == ST_DATA) & req.write;
    rd_load        = (accept_c & ~ahbl_hwrite_i & ~hazard_c) | (state == ST_WAIT);
    hreadyout_next = (state_next != ST_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req         <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
    end else begin
      if (accept_c) req <= '{addr: addr_word, write: ahbl_hwrite_i};
      if (rd_load)  hrdata_q <= rd_data_c;
      hreadyout_q <= hreadyout_next;
    end
  end

  assign we_status   = wr_en && (req.addr == OFF_STATUS);
  assign we_irq_en   = wr_en && (req.addr == OFF_IRQ_EN);
  assign we_prescale = wr_en && (req.addr == OFF_PRESCALE);
  assign we_gctrl    = wr_en && (req.addr == OFF_GCTRL);
  assign ch_wr_c     = wr_en && (req.addr >= CH_BASE);

  assign tick_c = run & (tick_cnt == prescale_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run        <= 1'b1;
      prescale_q <= PRESCALE_W'(PRESCALE);
      tick_cnt   <= '0;
      ticks      <= '0;
      irq_en     <= '0;
      status     <= '0;
      int_q      <= 1'b0;
    end else begin
      if (we_gctrl)    run        <= ahbl_hwdata_i[GCTRL_RUN];
      if (we_prescale) prescale_q <= ahbl_hwdata_i[PRESCALE_W-1:0];
      if (we_irq_en)   irq_en     <= ahbl_hwdata_i[NUM_CH-1:0];
      if (we_prescale)  tick_cnt <= '0;
      else if (tick_c)  tick_cnt <= '0;
      else if (run)     tick_cnt <= tick_cnt + PRESCALE_W'(1);
      if (tick_c) ticks <= ticks + CNT_W'(1);
      // Set from a fire wins over a same-cycle W1C.
      status <= (status & ~(we_status ? ahbl_hwdata_i[NUM_CH-1:0] : NUM_CH'(0))) | fire;
      int_q  <= |(status & irq_en);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ctrl_we[i]   = ch_wr_c && (ch_index(req.addr) == 4'(i)) && (req.addr[3:0] == CH_CTRL);
    assign period_we[i] = ch_wr_c && (ch_index(req.addr) == 4'(i)) && (req.addr[3:0] == CH_PERIOD);

    timer_mc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk_i),
      .rst       (rst_i),
      .tick      (tick_c),
      .ticks     (ticks),
      .ctrl_we   (ctrl_we[i]),
      .period_we (period_we[i]),
      .wdata     (ahbl_hwdata_i),
      .en        (en[i]),
      .periodic  (periodic[i]),
      .period    (period[i]),
      .alarm_end (alarm_end[i]),
      .fire_c    (fire[i])
    );
  end

  // A stalled read decodes its captured address once the write has landed.
  assign rd_addr = (state == ST_WAIT) ? req.addr : addr_word;

  always_comb begin
    rd_data_c = '0;
    if (rd_addr < CH_BASE) begin
      case (rd_addr)
        OFF_STATUS:   rd_data_c = 32'(status);
        OFF_IRQ_EN:   rd_data_c = 32'(irq_en);
        OFF_TICKS:    rd_data_c = 32'(ticks);
        OFF_PRESCALE: rd_data_c = 32'(prescale_q);
        OFF_GCTRL:    rd_data_c = 32'(run);
        default:      rd_data_c = '0;
      endcase
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_index(rd_addr) == 4'(i)) begin
          case (rd_addr[3:0])
            CH_CTRL:   rd_data_c = 32'({periodic[i], en[i]});
            CH_PERIOD: rd_data_c = 32'(period[i]);
            CH_END:    rd_data_c = 32'(alarm_end[i]);
            default:   rd_data_c = '0;
          endcase
        end
      end
    end
  end

  assign ahbl_hrdata_o    = hrdata_q;
  assign ahbl_hreadyout_o = hreadyout_q;
  assign ahbl_hresp_o     = 1'b0;
  assign int_o            = int_q;
  assign systime_o        = ticks;

endmodule

// File: tb/tb_timer_mc_ahbl.sv
// Directed bench for timer_mc_ahbl (16-bit counter build, four channels).
module tb_timer_mc_ahbl;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned PRESCALE_W = 8;
  localparam int unsigned PRESCALE   = 23;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      haddr, hwdata, hrdata;
  logic [1:0]       htrans;
  logic             hwrite, hsel, hreadyout, hresp, int_w;
  logic [2:0]       hsize, hburst;
  logic [CNT_W-1:0] systime;
  logic [31:0]      rd;
  int               total = 0;
  int               bad   = 0;

  always #5 clk = ~clk;

  timer_mc_ahbl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W), .PRESCALE(PRESCALE)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ahbl_haddr_i     (haddr),
    .ahbl_htrans_i    (htrans),
    .ahbl_hwrite_i    (hwrite),
    .ahbl_hsel_i      (hsel),
    .ahbl_hready_i    (hreadyout),
    .ahbl_hsize_i     (hsize),
    .ahbl_hburst_i    (hburst),
    .ahbl_hwdata_i    (hwdata),
    .ahbl_hrdata_o    (hrdata),
    .ahbl_hreadyout_o (hreadyout),
    .ahbl_hresp_o     (hresp),
    .int_o            (int_w),
    .systime_o        (systime)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
    @(posedge clk); #1;
    bus_idle(); hwdata = d;
  endtask

  // Two writes back to back: second address phase overlaps first data phase.
  task automatic pipe_write2(input logic [31:0] a1, input logic [31:0] d1,
                             input logic [31:0] a2, input logic [31:0] d2);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a1;
    @(posedge clk); #1;
    hwdata = d1; haddr = a2;
    @(posedge clk); #1;
    bus_idle(); hwdata = d2;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
    @(posedge clk); #1;
    bus_idle();
    n = 0;
    while (!hreadyout && n < 4) begin @(posedge clk); #1; n++; end
    d = hrdata;
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_int(input string tag, input int budget);
    int n = 0;
    while (!int_w && n < budget) begin @(posedge clk); #1; n++; end
    if (!int_w) check({tag, "_timeout"}, 32'(int_w), 32'd1);
  endtask

  task automatic wait_ticks(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(systime) < target && n < budget) begin @(posedge clk); #1; n++; end
    if (int'(systime) < target) check({tag, "_timeout"}, 32'(systime), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_idle(); haddr = '0; hwdata = '0; hsize = 3'b010; hburst = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_int", 32'(int_w), 32'd0);
    check("rst_systime", 32'(systime), 32'd0);
    rst = 1'b0;
    check_read("rst_prescale", 32'h0C, 32'd23);
    check_read("rst_gctrl", 32'h10, 32'd1);
    check_read("rst_status", 32'h00, 32'd0);
    check_read("unmapped_gap", 32'h14, 32'd0);
    bus_write(32'h90, 32'h3);
    check_read("unmapped_ch5", 32'h90, 32'd0);

    // One-shot ch0, PERIOD 5 armed at TICKS 0
    do_reset();
    bus_write(32'h10, 32'd0);
    bus_write(32'h0C, 32'd3);
    bus_write(32'h04, 32'd1);
    bus_write(32'h44, 32'd5);
    bus_write(32'h10, 32'd1);
    wait_int("os_fire", 200);
    check("os_fire_time", 32'(systime), 32'd5);
    check_read("os_status", 32'h00, 32'd1);
    check_read("os_en_clear", 32'h40, 32'd0);
    check_read("os_end", 32'h48, 32'd5);
    bus_write(32'h00, 32'd1);
    wait_ticks("os_run", 11, 200);
    check_read("os_no_refire", 32'h00, 32'd0);
    check("os_int_low", 32'(int_w), 32'd0);

    // Periodic ch1, PERIOD 4: fires at 4, 8, 12
    do_reset();
    bus_write(32'h10, 32'd0);
    bus_write(32'h0C, 32'd3);
    bus_write(32'h04, 32'd2);
    bus_write(32'h50, 32'd2);
    bus_write(32'h54, 32'd4);
    bus_write(32'h10, 32'd1);
    wait_int("per_fire1", 200);
    check("per_fire1_time", 32'(systime), 32'd4);
    check_read("per_status", 32'h00, 32'd2);
    bus_write(32'h00, 32'd2);
    @(posedge clk); #1;
    check("per_int_hold", 32'(int_w), 32'd1);
    @(posedge clk); #1;
    check("per_int_drop", 32'(int_w), 32'd0);
    wait_int("per_fire2", 200);
    check("per_fire2_time", 32'(systime), 32'd8);
    bus_write(32'h00, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    wait_int("per_fire3", 200);
    check("per_fire3_time", 32'(systime), 32'd12);
    check_read("per_end", 32'h58, 32'd16);
    check_read("per_ctrl", 32'h50, 32'd3);

    // Fire of ch0 and W1C of STATUS[0] on the same edge
    do_reset();
    bus_write(32'h10, 32'd0);
    bus_write(32'h0C, 32'd0);
    bus_write(32'h04, 32'd1);
    bus_write(32'h44, 32'd1);
    pipe_write2(32'h10, 32'd1, 32'h00, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("setwin_int", 32'(int_w), 32'd1);
    check_read("setwin_status", 32'h00, 32'd1);
    check("setwin_int_hold", 32'(int_w), 32'd1);

    // PERIOD write to ch2 on the edge it would have fired
    do_reset();
    bus_write(32'h10, 32'd0);
    bus_write(32'h0C, 32'd0);
    bus_write(32'h04, 32'd4);
    bus_write(32'h64, 32'd1);
    pipe_write2(32'h10, 32'd1, 32'h64, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    check("wrwin_int", 32'(int_w), 32'd0);
    check_read("wrwin_status", 32'h00, 32'd0);
    check_read("wrwin_end", 32'h68, 32'h100);
    check_read("wrwin_period", 32'h64, 32'h100);

    // Write PRESCALE with a read of it in the overlapping address phase
    do_reset();
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0C;
    @(posedge clk); #1;
    hwdata = 32'h5A; hwrite = 1'b0; haddr = 32'h0C;
    @(posedge clk); #1;
    bus_idle();
    check("haz_wait", 32'(hreadyout), 32'd0);
    @(posedge clk); #1;
    check("haz_ready", 32'(hreadyout), 32'd1);
    check("haz_rdata", hrdata, 32'h5A);

    // Counter wrap: arm ch3 PERIOD 3 at TICKS 0xFFFE
    do_reset();
    bus_write(32'h0C, 32'd0);
    wait_ticks("wrap_fast", 32'hFFF0, 70000);
    bus_write(32'h0C, 32'd255);
    wait_ticks("wrap_slow", 32'hFFFE, 5000);
    bus_write(32'h10, 32'd0);
    check_read("wrap_ticks", 32'h08, 32'hFFFE);
    bus_write(32'h04, 32'd8);
    bus_write(32'h74, 32'd3);
    check_read("wrap_end", 32'h78, 32'h1);
    bus_write(32'h0C, 32'd3);
    bus_write(32'h10, 32'd1);
    wait_int("wrap_fire", 200);
    check("wrap_fire_time", 32'(systime), 32'd1);
    check_read("wrap_status", 32'h00, 32'd8);

    // Reset in the data phase of a read, ch2 armed
    do_reset();
    bus_write(32'h10, 32'd0);
    bus_write(32'h0C, 32'd3);
    bus_write(32'h04, 32'd4);
    bus_write(32'h64, 32'd6);
    bus_write(32'h10, 32'd1);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h68;
    @(posedge clk); #1;
    bus_idle();
    check("rstmid_rdata_pre", hrdata, 32'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_hrdata", hrdata, 32'd0);
    check("rstmid_hreadyout", 32'(hreadyout), 32'd1);
    check("rstmid_int", 32'(int_w), 32'd0);
    check("rstmid_systime", 32'(systime), 32'd0);
    rst = 1'b0;
    check_read("rstmid_end", 32'h68, 32'd0);
    check_read("rstmid_ctrl", 32'h60, 32'd0);
    repeat (300) @(posedge clk);
    #1;
    check("rstmid_no_fire_int", 32'(int_w), 32'd0);
    check_read("rstmid_no_fire_status", 32'h00, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
